arbitro_maestro_avalon: RTL and testbench

Arbiter that shares one `avalon_master_interface` instance between `NUM_REQ` filter engines (line readers, result writers). Accepts held read/write requests, grants one requester at a time and issues a single one-cycle command to the master interface. Returns the completion and read data only to the granted requester. Sits between the filter datapath engines and the Avalon-MM master interface.

---
 rtl/arbitro_maestro_avalon_pkg.sv | 16 +
 rtl/arbitro_maestro_avalon_selector_round_robin.sv | 44 ++++
 rtl/arbitro_maestro_avalon.sv | 117 +++++++++++
 tb/tb_arbitro_maestro_avalon.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_maestro_avalon_pkg.sv
// Shared definitions for the Avalon master arbiter: FSM state encoding
// and the grant-index width helper.
package arbitro_maestro_avalon_pkg;

  typedef enum logic [1:0] {
    E_LIBRE   = 2'd0,
    E_EMITIR  = 2'd1,
    E_ESPERAR = 2'd2
  } estado_t;

  // Width of a binary requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_maestro_avalon_selector_round_robin.sv
// Combinational requester selector.
// Default: round-robin search starting after the last winner (ultimo).
// With ARBITRO_PRIORIDAD_FIJA_EN defined: fixed priority, lowest index
// wins and the ultimo input does not exist.
module selector_round_robin #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] solicitudes,
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
  input  logic [IDX_W-1:0]   ultimo,
`endif
  output logic [NUM_REQ-1:0] concesion,
  output logic [IDX_W-1:0]   indice,
  output logic               valido
);

  // Pick the winner; the first hit in search order is kept.
  always_comb begin
    int unsigned cand;
    valido = 1'b0;
    indice = '0;
    cand   = 0;
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = k;
      if (!valido && solicitudes[cand]) begin
        valido = 1'b1;
        indice = IDX_W'(cand);
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ultimo) + k) % NUM_REQ;
      if (!valido && solicitudes[cand]) begin
        valido = 1'b1;
        indice = IDX_W'(cand);
      end
    end
`endif
    concesion = valido ? (NUM_REQ'(1) << indice) : '0;
  end

endmodule

// File: rtl/arbitro_maestro_avalon.sv
// Shares one Avalon-MM master interface between NUM_REQ engines.
// One transaction at a time: arbitrate (E_LIBRE), issue a one-cycle
// command (E_EMITIR), wait for completion (E_ESPERAR). The ack and read
// data are returned combinationally to the granted requester only.
// Optional macro ARBITRO_PRIORIDAD_FIJA_EN selects fixed priority instead
// of round-robin.
module arbitro_maestro_avalon
  import arbitro_maestro_avalon_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_BITS    = 8,
  parameter int ADDRESS_BITS = 5
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_leer,
  input  logic [NUM_REQ-1:0]              req_escribir,
  input  logic [NUM_REQ*ADDRESS_BITS-1:0] req_direccion,
  input  logic [NUM_REQ*DATA_BITS-1:0]    req_datos_escribir,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [DATA_BITS-1:0]            req_datos_leidos,
  output logic [NUM_REQ-1:0]              concesion,
  output logic                            ocupado,
  output logic [ADDRESS_BITS-1:0]         m_direccion,
  output logic                            m_leer,
  output logic                            m_escribir,
  output logic [DATA_BITS-1:0]            m_datos_escribir,
  input  logic [DATA_BITS-1:0]            m_datos_leidos,
  input  logic                            m_transaccion_completada
);

  localparam int IDX_W = idx_w(NUM_REQ);

  estado_t                estado;
  logic [DATA_BITS-1:0]   dato_retenido;
  logic [NUM_REQ-1:0]     sel_concesion;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valido;
  logic                   fin_trans;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
  logic [IDX_W-1:0]       ultimo;
`endif

  selector_round_robin #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_selector (
    .solicitudes (req_leer | req_escribir),
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
    .ultimo      (ultimo),
`endif
    .concesion   (sel_concesion),
    .indice      (sel_idx),
    .valido      (sel_valido)
  );

  // Completion only counts while waiting; stray pulses elsewhere are dropped.
  assign fin_trans        = (estado == E_ESPERAR) && m_transaccion_completada;
  assign req_ack          = fin_trans ? concesion : '0;
  assign req_datos_leidos = fin_trans ? m_datos_leidos : dato_retenido;

  // Arbiter FSM with registered grant and command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado           <= E_LIBRE;
      concesion        <= '0;
      ocupado          <= 1'b0;
      m_leer           <= 1'b0;
      m_escribir       <= 1'b0;
      m_direccion      <= '0;
      m_datos_escribir <= '0;
      dato_retenido    <= '0;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
      ultimo           <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      case (estado)
        E_LIBRE: begin
          if (sel_valido) begin
            estado           <= E_EMITIR;
            concesion        <= sel_concesion;
            ocupado          <= 1'b1;
            // A combined read+write request is served as a write only.
            m_escribir       <= req_escribir[sel_idx];
            m_leer           <= req_leer[sel_idx] & ~req_escribir[sel_idx];
            m_direccion      <= req_direccion[sel_idx*ADDRESS_BITS +: ADDRESS_BITS];
            m_datos_escribir <= req_datos_escribir[sel_idx*DATA_BITS +: DATA_BITS];
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
            ultimo           <= sel_idx;
`endif
          end
        end
        E_EMITIR: begin
          estado           <= E_ESPERAR;
          m_leer           <= 1'b0;
          m_escribir       <= 1'b0;
          m_direccion      <= '0;
          m_datos_escribir <= '0;
        end
        E_ESPERAR: begin
          if (m_transaccion_completada) begin
            estado        <= E_LIBRE;
            concesion     <= '0;
            ocupado       <= 1'b0;
            dato_retenido <= m_datos_leidos;
          end
        end
        default: begin
          estado    <= E_LIBRE;
          concesion <= '0;
          ocupado   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_maestro_avalon.sv
// Bench for arbitro_maestro_avalon (NUM_REQ=2, DATA_BITS=8, ADDRESS_BITS=5).
// A transaction-level model predicts every output each cycle; requester and
// master behaviour are emulated in the same single process.
module tb_arbitro_maestro_avalon;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_leer, req_escribir;
  logic [9:0]  req_direccion;
  logic [15:0] req_datos_escribir;
  logic [1:0]  req_ack;
  logic [7:0]  req_datos_leidos;
  logic [1:0]  concesion;
  logic        ocupado;
  logic [4:0]  m_direccion;
  logic        m_leer, m_escribir;
  logic [7:0]  m_datos_escribir;
  logic [7:0]  m_datos_leidos;
  logic        m_transaccion_completada;

  arbitro_maestro_avalon #(.NUM_REQ(2), .DATA_BITS(8), .ADDRESS_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_leer(req_leer), .req_escribir(req_escribir),
    .req_direccion(req_direccion), .req_datos_escribir(req_datos_escribir),
    .req_ack(req_ack), .req_datos_leidos(req_datos_leidos),
    .concesion(concesion), .ocupado(ocupado),
    .m_direccion(m_direccion), .m_leer(m_leer), .m_escribir(m_escribir),
    .m_datos_escribir(m_datos_escribir), .m_datos_leidos(m_datos_leidos),
    .m_transaccion_completada(m_transaccion_completada)
  );

  always #5 clk = ~clk;

  int comps = 0, errs = 0, ciclo = 0;

  // requester emulation
  bit       act[2], op_l[2], op_e[2], recarga[2], ack_visto[2];
  logic [4:0] op_d[2];
  logic [7:0] op_w[2];
  int       rep[2];

  // master emulation
  logic [7:0] mem[32];
  int       pend = 0, espera = 0;
  bit       pulso_suelto = 0;
  logic [4:0] dir_actual = '0;

  // transaction-level model
  bit       mo_act = 0, mo_l = 0, mo_e = 0;
  int       mo_fase = 0, mo_g = 0, mo_ult = 1;
  logic [4:0] mo_d = '0;
  logic [7:0] mo_w = '0, mo_hold = '0;

  // observations
  int n_acks = 0, n_cmds = 0, n_ocup = 0, n_mesc = 0, t_cmd = -1;
  int ult_ack_c = 0;
  logic [1:0] ult_ack_v = '0;
  logic [7:0] ult_rd = '0;
  int orden[$];

  task automatic chk(input string nombre, input logic [31:0] act_v, input logic [31:0] exp_v);
    comps++;
    if (act_v !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, act_v, exp_v, ciclo);
    end
  endtask

  task automatic aplicar();
    for (int i = 0; i < 2; i++) begin
      req_leer[i]               = act[i] & op_l[i];
      req_escribir[i]           = act[i] & op_e[i];
      req_direccion[i*5 +: 5]   = act[i] ? op_d[i] : 5'd0;
      req_datos_escribir[i*8 +: 8] = act[i] ? op_w[i] : 8'd0;
    end
  endtask

  task automatic pedir(input int i, input bit l, input bit e, input logic [4:0] d,
                       input logic [7:0] w, input int r);
    op_l[i] = l; op_e[i] = e; op_d[i] = d; op_w[i] = w; rep[i] = r;
    act[i] = 1; recarga[i] = 0; ack_visto[i] = 0;
    aplicar();
  endtask

  // Model: advance one clock using the inputs the DUT samples at this edge.
  task automatic modelo_avanzar();
    int gan;
    if (!reset_n) begin
      mo_act = 0; mo_fase = 0; mo_ult = 1; mo_hold = '0;
    end else if (!mo_act) begin
      gan = -1;
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
      for (int k = 0; k < 2; k++)
        if (gan < 0 && (req_leer[k] | req_escribir[k])) gan = k;
`else
      for (int k = 1; k <= 2; k++)
        if (gan < 0 && (req_leer[(mo_ult+k)%2] | req_escribir[(mo_ult+k)%2])) gan = (mo_ult+k)%2;
`endif
      if (gan >= 0) begin
        mo_act = 1; mo_fase = 1; mo_g = gan; mo_ult = gan;
        mo_e = req_escribir[gan];
        mo_l = req_leer[gan] & ~req_escribir[gan];
        mo_d = req_direccion[gan*5 +: 5];
        mo_w = req_datos_escribir[gan*8 +: 8];
      end
    end else if (mo_fase == 1) begin
      mo_fase = 2;
    end else if (m_transaccion_completada) begin
      mo_hold = m_datos_leidos;
      mo_act  = 0;
    end
  endtask

  task automatic maestro();
    if (!reset_n) begin
      pend = 0; m_transaccion_completada = 0;
    end else begin
      m_transaccion_completada = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) m_transaccion_completada = 1;
      end
      if (pulso_suelto) begin
        m_transaccion_completada = 1; pulso_suelto = 0;
      end
      if (m_leer | m_escribir) begin
        pend = 2 + espera;
        dir_actual = m_direccion;
        if (m_escribir) mem[m_direccion] = m_datos_escribir;
      end
    end
    m_datos_leidos = m_transaccion_completada ? mem[dir_actual] : 8'($urandom);
  endtask

  task automatic solicitantes();
    for (int i = 0; i < 2; i++) begin
      if (ack_visto[i]) begin
        ack_visto[i] = 0; act[i] = 0;
        if (rep[i] > 0) begin rep[i]--; recarga[i] = 1; end
      end else if (recarga[i]) begin
        recarga[i] = 0; act[i] = 1;
      end
    end
    aplicar();
  endtask

  task automatic comprobar();
    bit         cmd;
    logic [1:0] e_conc, e_ack;
    e_conc = mo_act ? 2'(1 << mo_g) : 2'b00;
    cmd    = mo_act && (mo_fase == 1);
    e_ack  = (mo_act && mo_fase >= 2 && m_transaccion_completada) ? e_conc : 2'b00;
    chk("concesion", concesion, e_conc);
    chk("ocupado", ocupado, mo_act);
    chk("m_leer", m_leer, cmd & mo_l);
    chk("m_escribir", m_escribir, cmd & mo_e);
    chk("m_direccion", m_direccion, cmd ? mo_d : 5'd0);
    chk("m_datos_escribir", m_datos_escribir, cmd ? mo_w : 8'd0);
    chk("req_ack", req_ack, e_ack);
    chk("req_datos_leidos", req_datos_leidos, (e_ack != 0) ? m_datos_leidos : mo_hold);
    if (req_ack != 0) begin
      n_acks++; ult_ack_c = ciclo; ult_ack_v = req_ack; ult_rd = req_datos_leidos;
      for (int i = 0; i < 2; i++) if (req_ack[i]) ack_visto[i] = 1;
    end
    if (m_leer | m_escribir) begin
      n_cmds++;
      orden.push_back(concesion == 2'b10 ? 1 : 0);
      if (t_cmd < 0) t_cmd = ciclo;
    end
    if (m_escribir) n_mesc++;
    if (ocupado) n_ocup++;
  endtask

  task automatic ciclo_tb();
    @(posedge clk);
    ciclo++;
    modelo_avanzar();
    @(negedge clk);
    maestro();
    solicitantes();
    #1;
    comprobar();
  endtask

  task automatic esperar(input int n);
    for (int k = 0; k < n; k++) ciclo_tb();
  endtask

  task automatic esperar_libre(input string nombre, input int tope);
    int k;
    k = 0;
    while ((mo_act || act[0] || act[1] || recarga[0] || recarga[1] ||
            ack_visto[0] || ack_visto[1]) && k < tope) begin
      ciclo_tb(); k++;
    end
    if (k >= tope) begin
      comps++; errs++;
      $display("FAIL %s: timeout after %0d cycles, still busy", nombre, tope);
      act[0] = 0; act[1] = 0; recarga[0] = 0; recarga[1] = 0;
      ack_visto[0] = 0; ack_visto[1] = 0; aplicar();
    end
    esperar(1);
  endtask

  initial begin
    int t0, a0, c0, o0;
    int exp_orden[4];
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);
    m_transaccion_completada = 0;
    m_datos_leidos = '0;
    reset_n = 0;
    pedir(0, 1, 0, 5'd1, 8'h00, 0);
    pedir(1, 1, 0, 5'd2, 8'h00, 0);

    // reset with both requesters reading
    esperar(3);
    chk("reset_concesion", concesion, 2'b00);
    chk("reset_m_leer", m_leer, 0);
    chk("reset_req_ack", req_ack, 2'b00);
    chk("reset_datos", req_datos_leidos, 8'h00);
    reset_n = 1;
    t0 = ciclo;
    esperar(1);
    chk("primera_concesion", concesion, 2'b01);
    chk("primer_m_leer", m_leer, 1);
    chk("primer_t_cmd", t_cmd - t0, 1);
    esperar_libre("reset_drain", 40);

    // single read, zero wait
    mem[5'h0A] = 8'h3C;
    pedir(1, 1, 0, 5'h0A, 8'h00, 0);
    t0 = ciclo;
    esperar_libre("lectura", 40);
    chk("lectura_latencia_ack", ult_ack_c - t0, 3);
    chk("lectura_ack", ult_ack_v, 2'b10);
    chk("lectura_dato", ult_rd, 8'h3C);
    esperar(2);
    chk("lectura_retenida", req_datos_leidos, 8'h3C);

    // leave requester 0 as last winner, then contention with writes
    pedir(0, 1, 0, 5'd1, 8'h00, 0);
    esperar_libre("previo", 40);
    orden.delete();
    o0 = n_mesc;
    pedir(0, 0, 1, 5'd3, 8'hA1, 1);
    pedir(1, 0, 1, 5'd4, 8'hB2, 1);
    esperar_libre("contencion", 80);
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    exp_orden = '{0, 1, 0, 1};
`else
    exp_orden = '{1, 0, 1, 0};
`endif
    chk("contencion_n", orden.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < orden.size()) chk($sformatf("contencion_orden%0d", k), orden[k], exp_orden[k]);
    chk("contencion_ciclos_escritura", n_mesc - o0, 4);

    // long wait
    espera = 10;
    a0 = n_acks; c0 = n_cmds; o0 = n_ocup;
    pedir(0, 1, 0, 5'd7, 8'h00, 0);
    esperar_libre("espera_larga", 60);
    chk("espera_larga_cmds", n_cmds - c0, 1);
    chk("espera_larga_acks", n_acks - a0, 1);
    chk("espera_larga_ocupado", n_ocup - o0, 13);
    espera = 0;

    // stray completion while idle
    a0 = n_acks;
    pulso_suelto = 1;
    esperar(2);
    chk("pulso_suelto_acks", n_acks - a0, 0);

    // read+write together, then reset while waiting
    pedir(0, 1, 1, 5'd9, 8'h55, 0);
    esperar(1);
    chk("rw_m_escribir", m_escribir, 1);
    chk("rw_m_leer", m_leer, 0);
    chk("rw_datos", m_datos_escribir, 8'h55);
    esperar(1);
    chk("rw_ocupado", ocupado, 1);
    a0 = n_acks;
    reset_n = 0;
    act[0] = 0; aplicar();
    esperar(2);
    chk("rst_medio_concesion", concesion, 2'b00);
    chk("rst_medio_ocupado", ocupado, 0);
    reset_n = 1;
    esperar(3);
    chk("rst_medio_acks", n_acks - a0, 0);

    // mixed traffic with varying waits
    for (int r = 0; r < 6; r++) begin
      espera = r % 3;
      pedir(0, 1'(r % 2), 1'((r + 1) % 2), 5'(r + 10), 8'(r * 17), r % 2);
      pedir(1, 1'(r % 3 == 0), 1'(r % 3 != 0), 5'(r + 20), 8'(r * 29 + 3), 0);
      esperar_libre("mixto", 120);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
